// File: rtl/dm_sram_responder_pkg.sv
// Shared types and constants for the data-memory responder and the CPU MEM stage.
package dm_sram_responder_pkg;

    // Boot loader / serving state of the responder
    typedef enum logic [1:0] {
        LD_LOAD  = 2'd0,
        LD_FLUSH = 2'd1,
        LD_RUN   = 2'd2
    } ld_state_e;

    // DM_WEB is active low: all ones writes nothing, all zeros writes the whole word
    localparam logic [3:0] WEB_NONE = 4'b1111;
    localparam logic [3:0] WEB_WORD = 4'b0000;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LANES   = 4;

endpackage

// File: rtl/dm_sram_responder_byte_array.sv
// Single-port word array with per-byte write enables and a write-first registered read.
module sram_byte_array #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_clr_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;
    logic [31:0] rd_merge;

    // Post-write view of the addressed word, so a same-edge read sees the new lanes
    always_comb begin
        rd_merge = mem_q[addr_i];
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                rd_merge[8*i +: 8] = wdata_i[8*i +: 8];
            end
        end
    end

    // Byte-lane writes; array contents are intentionally not reset
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Registered read data, forced to zero while the array is not serving reads
    always_ff @(posedge clk_i) begin
        if (rst_i || rd_clr_i) begin
            rdata_q <= 32'h0;
        end else begin
            rdata_q <= rd_merge;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_sram_responder.sv
// Data-memory responder: boot loader fills the array from a byte stream, then serves CPU DM traffic.
module dm_sram_responder
    import dm_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned LOAD_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DM_OE,
    input  logic [3:0]        DM_WEB,
    input  logic [ADDR_W-1:0] DM_A,
    input  logic [31:0]       DM_DI,
    output logic [31:0]       DM_DO,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              init_done
);

    ld_state_e         state_q, state_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [ADDR_W-1:0] lptr_q, lptr_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       asm_fill;
    logic              ld_ready_q, init_done_q;

    logic [3:0]        arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [31:0]       arr_wdata;
    logic [31:0]       arr_rdata;
    logic              arr_rd_clr;

    // Assembly word with the incoming loader byte dropped into the current lane
    always_comb begin
        asm_fill = asm_q;
        asm_fill[{bcnt_q, 3'b000} +: 8] = ld_data;
    end

    // Next-state logic and array port mux between loader and CPU
    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        lptr_d    = lptr_q;
        asm_d     = asm_q;
        arr_we    = 4'b0000;
        arr_addr  = lptr_q;
        arr_wdata = asm_q;

        case (state_q)
            LD_LOAD: begin
                if (ld_valid) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        arr_we    = ~WEB_WORD;
                        arr_wdata = asm_fill;
                        asm_d     = 32'h0;
                        lptr_d    = lptr_q + ADDR_W'(1);
                    end else begin
                        asm_d     = asm_fill;
                    end
                    if (ld_last) begin
                        state_d = (bcnt_q == 2'd3) ? LD_RUN : LD_FLUSH;
                    end
                end
            end
            LD_FLUSH: begin
                // Unfilled lanes are already zero because the assembly clears after every word
                arr_we  = ~WEB_WORD;
                asm_d   = 32'h0;
                lptr_d  = lptr_q + ADDR_W'(1);
                state_d = LD_RUN;
            end
            LD_RUN: begin
                arr_addr  = DM_A;
                arr_we    = ~DM_WEB;
                arr_wdata = DM_DI;
            end
            default: begin
                state_d = LD_LOAD;
            end
        endcase

        // Nothing reaches the array on a reset edge; a partial assembly is dropped
        if (rst) begin
            arr_we = 4'b0000;
        end
    end

    // State, loader counters and registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LD_LOAD;
            bcnt_q      <= 2'd0;
            lptr_q      <= ADDR_W'(LOAD_BASE);
            asm_q       <= 32'h0;
            ld_ready_q  <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            lptr_q      <= lptr_d;
            asm_q       <= asm_d;
            ld_ready_q  <= (state_d == LD_LOAD);
            init_done_q <= (state_d == LD_RUN);
        end
    end

    assign arr_rd_clr = (state_q != LD_RUN);

    sram_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i    (clk),
        .rst_i    (rst),
        .rd_clr_i (arr_rd_clr),
        .we_i     (arr_we),
        .addr_i   (arr_addr),
        .wdata_i  (arr_wdata),
        .rdata_o  (arr_rdata)
    );

    // Output enable gates the registered read data without adding latency
    assign DM_DO     = DM_OE ? arr_rdata : 32'h0;
    assign ld_ready  = ld_ready_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_dm_sram_responder.sv
// Directed bench for dm_sram_responder: loader paths, byte writes, write-first reads, resets.
module tb_dm_sram_responder;
    import dm_sram_responder_pkg::*;

    localparam int unsigned ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              DM_OE;
    logic [3:0]        DM_WEB;
    logic [ADDR_W-1:0] DM_A;
    logic [31:0]       DM_DI;
    logic [31:0]       DM_DO;
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              init_done;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        string             name;
        logic [ADDR_W-1:0] a;
        logic [3:0]        web;
        logic [31:0]       di;
        logic              oe;
        logic [31:0]       exp_do;
    } vec_t;

    vec_t vecs[11];

    dm_sram_responder #(
        .ADDR_W    (ADDR_W),
        .LOAD_BASE (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .DM_OE     (DM_OE),
        .DM_WEB    (DM_WEB),
        .DM_A      (DM_A),
        .DM_DI     (DM_DI),
        .DM_DO     (DM_DO),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One CPU cycle: drive port, clock, check DM_DO for that cycle
    task automatic run_vec(input vec_t v);
        DM_A   = v.a;
        DM_WEB = v.web;
        DM_DI  = v.di;
        DM_OE  = v.oe;
        tick();
        check(v.name, DM_DO, v.exp_do);
        DM_WEB = WEB_NONE;
    endtask

    task automatic rd(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        vec_t v;
        v.name = name; v.a = a; v.web = WEB_NONE; v.di = 32'h0; v.oe = 1'b1; v.exp_do = exp;
        run_vec(v);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        check("ld_ready_beat", 32'(ld_ready), 32'd1);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Reset with OE high, checking that RUN status drops and read data is zero
    task automatic do_reset();
        rst   = 1'b1;
        DM_OE = 1'b1;
        tick();
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_do", DM_DO, 32'h0);
        tick();
        rst = 1'b0;
        check("rst_ld_ready", 32'(ld_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; DM_OE = 1'b0; DM_WEB = WEB_NONE; DM_A = '0; DM_DI = '0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;

        vecs[0]  = '{"rd_w0",        14'd0, WEB_NONE, 32'h0,        1'b1, 32'h14131211};
        vecs[1]  = '{"rd_w1",        14'd1, WEB_NONE, 32'h0,        1'b1, 32'h18171615};
        vecs[2]  = '{"wr_w3_oe0",    14'd3, WEB_WORD, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[3]  = '{"rd_w3",        14'd3, WEB_NONE, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[4]  = '{"rd_w3_oe0",    14'd3, WEB_NONE, 32'h0,        1'b0, 32'h0};
        vecs[5]  = '{"bytewr_w3_wf", 14'd3, 4'b1101,  32'h00005A00, 1'b1, 32'hDEAD5AEF};
        vecs[6]  = '{"rd_w3_merged", 14'd3, WEB_NONE, 32'h0,        1'b1, 32'hDEAD5AEF};
        vecs[7]  = '{"wr_w7_wf",     14'd7, WEB_WORD, 32'h01234567, 1'b1, 32'h01234567};
        vecs[8]  = '{"bytewr_w7_wf", 14'd7, 4'b0111,  32'hAB000000, 1'b1, 32'hAB234567};
        vecs[9]  = '{"rd_w7",        14'd7, WEB_NONE, 32'h0,        1'b1, 32'hAB234567};
        vecs[10] = '{"rd_w0_again",  14'd0, WEB_NONE, 32'h0,        1'b1, 32'h14131211};

        // Reset state
        tick(); tick();
        rst = 1'b0;
        DM_OE = 1'b1;
        check("reset_ld_ready", 32'(ld_ready), 32'd1);
        check("reset_init_done", 32'(init_done), 32'd0);
        check("reset_do", DM_DO, 32'h0);

        // Full-word load of 8 bytes, then CPU traffic
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(8'h11 + i), i == 7);
            if (i == 6) check("init_done_before_last", 32'(init_done), 32'd0);
        end
        check("full_init_done", 32'(init_done), 32'd1);
        check("full_ld_ready", 32'(ld_ready), 32'd0);
        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Reset in RUN; CPU write attempt in LOAD is ignored; partial load flushes
        do_reset();
        DM_A = 14'd3; DM_WEB = WEB_WORD; DM_DI = 32'h0; DM_OE = 1'b1;
        tick();
        check("load_do_zero", DM_DO, 32'h0);
        DM_WEB = WEB_NONE;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        send_byte(8'hEE, 1'b1);
        check("flush_init_done", 32'(init_done), 32'd0);
        check("flush_ld_ready", 32'(ld_ready), 32'd0);
        check("flush_do_zero", DM_DO, 32'h0);
        tick();
        check("partial_init_done", 32'(init_done), 32'd1);
        rd("p_rd_w0", 14'd0, 32'hDDCCBBAA);
        rd("p_rd_w1", 14'd1, 32'h000000EE);
        rd("p_rd_w3_kept", 14'd3, 32'hDEAD5AEF);
        rd("p_rd_w7_kept", 14'd7, 32'hAB234567);

        // Reset mid-load after 6 bytes; reload restarts at word 0, lane 0
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h21 + i), 1'b0);
        do_reset();
        check("midload_init_done", 32'(init_done), 32'd0);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h01 + i), i == 3);
        check("reload_init_done", 32'(init_done), 32'd1);
        rd("r_rd_w0", 14'd0, 32'h04030201);
        rd("r_rd_w1", 14'd1, 32'h000000EE);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
